// File: rtl/execute_mem_pipe.sv
// EX/MEM stage register and data-memory initiator for the pipelined RV32I core.
// Captures one instruction per slot while IDLE, runs a req/ack data-memory
// access for loads/stores in ACCESS (stalling upstream), and presents each
// completed instruction to writeback for exactly one cycle.
// Optional build macro MISALIGN_TRAP_EN: misaligned halfword/word accesses
// complete without a memory request and raise misalign_err; when undefined
// the low address bits are forced aligned for lane selection.
module execute_mem_pipe #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic            flush_in,
   input  logic            load_in,
   input  logic            store_in,
   input  logic            reg_write_in,
   input  logic [1:0]      mem_to_reg_in,
   input  logic [XLEN-1:0] alu_result_in,
   input  logic [XLEN-1:0] opb_data_in,
   input  logic [XLEN-1:0] pre_address_in,
   input  logic [XLEN-1:0] instruction_in,
   output logic            stall_out,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [3:0]      mem_mask,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            valid_out,
   output logic            reg_write_out,
   output logic [1:0]      mem_to_reg_out,
   output logic [XLEN-1:0] alu_result_out,
   output logic [XLEN-1:0] load_data_out,
   output logic [XLEN-1:0] pre_address_out,
   output logic [XLEN-1:0] instruction_out,
   output logic [4:0]      rd_addr_out,
`ifdef MISALIGN_TRAP_EN
   output logic            misalign_err,
`endif
   output logic            timeout_err
);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 2);

   state_t            state_q, state_d;
   logic              valid_q, valid_d;
   logic              load_q, load_d;
   logic              we_q, we_d;
   logic              reg_write_q, reg_write_d;
   logic [1:0]        m2r_q, m2r_d;
   logic [XLEN-1:0]   alu_q, alu_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   instr_q, instr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [3:0]        mask_q, mask_d;
   logic [XLEN-1:0]   ldata_q, ldata_d;
   logic              aborted_q, aborted_d;
   logic              terr_q, terr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     cnt_inc;
`ifdef MISALIGN_TRAP_EN
   logic              misalign_q, misalign_d;
`endif

   logic [2:0]        f3_in;
   logic [1:0]        a_in;
   logic [3:0]        st_mask;
   logic [XLEN-1:0]   st_wdata;
   logic              misal;
   logic [2:0]        f3_q;
   logic [1:0]        a_q;
   logic [XLEN-1:0]   sh_b, sh_h;
   logic [XLEN-1:0]   ld_ext;
   logic              is_mem_in;

   assign f3_in     = instruction_in[14:12];
   assign a_in      = alu_result_in[1:0];
   assign f3_q      = instr_q[14:12];
   assign a_q       = alu_q[1:0];
   assign cnt_inc   = cnt_q + CW'(1);
   assign is_mem_in = in_valid && !flush_in && (load_in || store_in);

   // Byte-enable mask, replicated store data and alignment check for the incoming op
   always_comb begin
      st_mask  = '0;
      st_wdata = '0;
      misal    = 1'b0;
      case (f3_in[1:0])
         2'b00: begin
            st_mask  = 4'b0001 << a_in;
            st_wdata = {4{opb_data_in[7:0]}};
         end
         2'b01: begin
            st_mask  = 4'b0011 << {a_in[1], 1'b0};
            st_wdata = {2{opb_data_in[15:0]}};
            misal    = a_in[0];
         end
         default: begin
            st_mask  = 4'b1111;
            st_wdata = opb_data_in;
            misal    = (a_in != 2'b00);
         end
      endcase
   end

   // Shift the addressed lane of read data down and extend it per funct3
   always_comb begin
      sh_b   = mem_rdata >> {a_q, 3'b000};
      sh_h   = mem_rdata >> {a_q[1], 4'b0000};
      ld_ext = mem_rdata;
      case (f3_q)
         3'b000:  ld_ext = {{24{sh_b[7]}}, sh_b[7:0]};
         3'b001:  ld_ext = {{16{sh_h[15]}}, sh_h[15:0]};
         3'b100:  ld_ext = {24'h0, sh_b[7:0]};
         3'b101:  ld_ext = {16'h0, sh_h[15:0]};
         default: ld_ext = mem_rdata;
      endcase
   end

   // Next-state: slot capture in IDLE, ack/timeout handling in ACCESS
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      load_d      = load_q;
      we_d        = we_q;
      reg_write_d = reg_write_q;
      m2r_d       = m2r_q;
      alu_d       = alu_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      wdata_d     = wdata_q;
      mask_d      = mask_q;
      ldata_d     = ldata_q;
      aborted_d   = aborted_q;
      terr_d      = terr_q;
      cnt_d       = cnt_q;
`ifdef MISALIGN_TRAP_EN
      misalign_d  = misalign_q;
`endif
      case (state_q)
         IDLE: begin
            valid_d     = in_valid && !flush_in;
            load_d      = load_in;
            we_d        = store_in && !load_in;
            reg_write_d = reg_write_in;
            m2r_d       = mem_to_reg_in;
            alu_d       = alu_result_in;
            pc_d        = pre_address_in;
            instr_d     = instruction_in;
            wdata_d     = st_wdata;
            mask_d      = st_mask;
            aborted_d   = 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_d  = 1'b0;
            if (is_mem_in) begin
               if (misal) begin
                  misalign_d = 1'b1;
                  aborted_d  = 1'b1;
               end else begin
                  state_d = ACCESS;
                  cnt_d   = '0;
               end
            end
`else
            if (is_mem_in) begin
               state_d = ACCESS;
               cnt_d   = '0;
            end
`endif
         end
         ACCESS: begin
            // An ack on the expiry edge takes priority over the timeout
            if (mem_ack) begin
               state_d = IDLE;
               if (load_q) ldata_d = ld_ext;
            end else if ((TIMEOUT_CYCLES != 0) && (32'(cnt_inc) == TIMEOUT_CYCLES)) begin
               state_d   = IDLE;
               aborted_d = 1'b1;
               terr_d    = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and slot registers with asynchronous active-high reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         valid_q     <= 1'b0;
         load_q      <= 1'b0;
         we_q        <= 1'b0;
         reg_write_q <= 1'b0;
         m2r_q       <= '0;
         alu_q       <= '0;
         pc_q        <= '0;
         instr_q     <= '0;
         wdata_q     <= '0;
         mask_q      <= '0;
         ldata_q     <= '0;
         aborted_q   <= 1'b0;
         terr_q      <= 1'b0;
         cnt_q       <= '0;
`ifdef MISALIGN_TRAP_EN
         misalign_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         load_q      <= load_d;
         we_q        <= we_d;
         reg_write_q <= reg_write_d;
         m2r_q       <= m2r_d;
         alu_q       <= alu_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         wdata_q     <= wdata_d;
         mask_q      <= mask_d;
         ldata_q     <= ldata_d;
         aborted_q   <= aborted_d;
         terr_q      <= terr_d;
         cnt_q       <= cnt_d;
`ifdef MISALIGN_TRAP_EN
         misalign_q  <= misalign_d;
`endif
      end
   end

   assign stall_out       = (state_q == ACCESS);
   assign mem_req         = (state_q == ACCESS);
   assign mem_we          = mem_req && we_q;
   assign mem_addr        = mem_req ? alu_q : '0;
   assign mem_wdata       = mem_req ? wdata_q : '0;
   assign mem_mask        = mem_req ? mask_q : '0;
   assign valid_out       = valid_q && (state_q == IDLE);
   assign reg_write_out   = reg_write_q && valid_out && !aborted_q;
   assign mem_to_reg_out  = m2r_q;
   assign alu_result_out  = alu_q;
   assign load_data_out   = ldata_q;
   assign pre_address_out = pc_q;
   assign instruction_out = instr_q;
   assign rd_addr_out     = instr_q[11:7];
   assign timeout_err     = terr_q;
`ifdef MISALIGN_TRAP_EN
   assign misalign_err    = valid_out && misalign_q;
`endif

endmodule

// File: tb/tb_execute_mem_pipe.sv
// Directed bench for execute_mem_pipe (default build, TIMEOUT_CYCLES = 16).
module tb_execute_mem_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, flush_in, load_in, store_in, reg_write_in;
   logic [1:0]  mem_to_reg_in;
   logic [31:0] alu_result_in, opb_data_in, pre_address_in, instruction_in;
   logic        stall_out, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_mask;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        valid_out, reg_write_out;
   logic [1:0]  mem_to_reg_out;
   logic [31:0] alu_result_out, load_data_out, pre_address_out, instruction_out;
   logic [4:0]  rd_addr_out;
   logic        timeout_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   execute_mem_pipe #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .flush_in(flush_in),
      .load_in(load_in), .store_in(store_in), .reg_write_in(reg_write_in),
      .mem_to_reg_in(mem_to_reg_in), .alu_result_in(alu_result_in),
      .opb_data_in(opb_data_in), .pre_address_in(pre_address_in),
      .instruction_in(instruction_in), .stall_out(stall_out), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_mask(mem_mask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .valid_out(valid_out), .reg_write_out(reg_write_out),
      .mem_to_reg_out(mem_to_reg_out), .alu_result_out(alu_result_out),
      .load_data_out(load_data_out), .pre_address_out(pre_address_out),
      .instruction_out(instruction_out), .rd_addr_out(rd_addr_out),
      .timeout_err(timeout_err)
   );

   typedef struct {
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] opb;
      logic [31:0] rdata;
      logic [3:0]  mask;
      logic [31:0] wdata;
      logic [31:0] ldata;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid       = 1'b0;
      flush_in       = 1'b0;
      load_in        = 1'b0;
      store_in       = 1'b0;
      reg_write_in   = 1'b0;
      mem_to_reg_in  = 2'b00;
      alu_result_in  = 32'h0;
      opb_data_in    = 32'h0;
      pre_address_in = 32'h0;
      instruction_in = 32'h0;
   endtask

   task automatic issue(input logic ld, input logic st, input logic rw, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] opb,
                        input logic [31:0] pc);
      in_valid       = 1'b1;
      flush_in       = 1'b0;
      load_in        = ld;
      store_in       = st;
      reg_write_in   = rw;
      mem_to_reg_in  = ld ? 2'b01 : 2'b00;
      alu_result_in  = addr;
      opb_data_in    = opb;
      pre_address_in = pc;
      instruction_in = {17'h0, f3, rd, 7'h03};
   endtask

   initial begin
      int n;
      vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8012_3456, 4'b1000, 32'h0, 32'hFFFF_FF80};
      vecs[1]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0, 32'h1234_F600, 4'b0010, 32'h0, 32'h0000_00F6};
      vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 4'b1100, 32'h0, 32'hFFFF_8001};
      vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0200, 32'h0, 32'h8001_9ABC, 4'b0011, 32'h0, 32'h0000_9ABC};
      vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'hDEAD_BEEF};
      vecs[5]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0102, 32'h0000_00A5, 32'h0, 4'b0100, 32'hA5A5_A5A5, 32'h0};
      vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 4'b1100, 32'hABCD_ABCD, 32'h0};
      vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h1122_3344, 32'h0, 4'b1111, 32'h1122_3344, 32'h0};
      vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0203, 32'h0, 32'hC000_1234, 4'b1100, 32'h0, 32'hFFFF_C000};
      vecs[9]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0401, 32'h5566_7788, 32'h0, 4'b1111, 32'h5566_7788, 32'h0};
      vecs[10] = '{1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0, 32'hFFFF_FF7F, 4'b0001, 32'h0, 32'h0000_007F};

      idle_inputs();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      rst       = 1'b1;
      #12;
      check("rst_valid", valid_out, 0);
      check("rst_stall", stall_out, 0);
      check("rst_req", mem_req, 0);
      check("rst_terr", timeout_err, 0);
      check("rst_alu", alu_result_out, 0);
      rst = 1'b0;
      step();

      // R-type passthrough
      issue(1'b0, 1'b0, 1'b1, 3'b000, 5'd7, 32'h0000_1234, 32'h0, 32'h0000_0040);
      step();
      idle_inputs();
      check("rt_valid", valid_out, 1);
      check("rt_rw", reg_write_out, 1);
      check("rt_alu", alu_result_out, 32'h1234);
      check("rt_pc", pre_address_out, 32'h40);
      check("rt_rd", rd_addr_out, 7);
      check("rt_stall", stall_out, 0);
      check("rt_req", mem_req, 0);
      step();
      check("rt_once", valid_out, 0);

      // Lane / extension table, ack on the first ACCESS cycle
      for (int i = 0; i < 11; i++) begin
         issue(vecs[i].ld, vecs[i].st, vecs[i].ld, vecs[i].f3, 5'(i + 1),
               vecs[i].addr, vecs[i].opb, 32'h1000 + 32'(4 * i));
         step();
         idle_inputs();
         check($sformatf("v%0d_req", i), mem_req, 1);
         check($sformatf("v%0d_stall", i), stall_out, 1);
         check($sformatf("v%0d_we", i), mem_we, vecs[i].st);
         check($sformatf("v%0d_addr", i), mem_addr, vecs[i].addr);
         check($sformatf("v%0d_mask", i), mem_mask, vecs[i].mask);
         if (vecs[i].st) check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].wdata);
         check($sformatf("v%0d_early", i), valid_out, 0);
         mem_ack   = 1'b1;
         mem_rdata = vecs[i].rdata;
         step();
         mem_ack   = 1'b0;
         check($sformatf("v%0d_valid", i), valid_out, 1);
         check($sformatf("v%0d_req_off", i), mem_req, 0);
         check($sformatf("v%0d_rw", i), reg_write_out, vecs[i].ld);
         check($sformatf("v%0d_rd", i), rd_addr_out, 5'(i + 1));
         check($sformatf("v%0d_pc", i), pre_address_out, 32'h1000 + 32'(4 * i));
         if (vecs[i].ld) check($sformatf("v%0d_ldata", i), load_data_out, vecs[i].ldata);
         step();
         check($sformatf("v%0d_once", i), valid_out, 0);
      end

      // LB at 0x103 with 3 wait cycles: stall for 4 cycles, stable request
      issue(1'b1, 1'b0, 1'b1, 3'b000, 5'd3, 32'h0000_0103, 32'h0, 32'h2000);
      step();
      idle_inputs();
      n = 0;
      for (int w = 0; w < 4; w++) begin
         if (stall_out) n++;
         check("lb_mask", mem_mask, 4'b1000);
         check("lb_addr", mem_addr, 32'h103);
         check("lb_valid_low", valid_out, 0);
         if (w == 3) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'h80AB_CDEF;
         end
         step();
      end
      mem_ack = 1'b0;
      check("lb_stall_cycles", n, 4);
      check("lb_valid", valid_out, 1);
      check("lb_ldata", load_data_out, 32'hFFFF_FF80);
      check("lb_stall_off", stall_out, 0);
      step();
      check("lb_once", valid_out, 0);

      // SH at 0x102 held across 2 wait cycles
      issue(1'b0, 1'b1, 1'b0, 3'b001, 5'd0, 32'h0000_0102, 32'h0000_ABCD, 32'h2004);
      step();
      idle_inputs();
      for (int w = 0; w < 3; w++) begin
         check("sh_we", mem_we, 1);
         check("sh_mask", mem_mask, 4'b1100);
         check("sh_wdata", mem_wdata, 32'hABCD_ABCD);
         if (w == 2) mem_ack = 1'b1;
         step();
      end
      mem_ack = 1'b0;
      check("sh_valid", valid_out, 1);
      check("sh_rw", reg_write_out, 0);
      step();

      // Ack on the same edge as expiry: normal completion
      issue(1'b1, 1'b0, 1'b1, 3'b010, 5'd9, 32'h0000_0600, 32'h0, 32'h2008);
      step();
      idle_inputs();
      repeat (15) step();
      check("edge_req", mem_req, 1);
      mem_ack   = 1'b1;
      mem_rdata = 32'h0BAD_F00D;
      step();
      mem_ack = 1'b0;
      check("edge_valid", valid_out, 1);
      check("edge_rw", reg_write_out, 1);
      check("edge_ldata", load_data_out, 32'h0BAD_F00D);
      check("edge_terr", timeout_err, 0);
      step();

      // Flush in IDLE squashes a load
      issue(1'b1, 1'b0, 1'b1, 3'b010, 5'd4, 32'h0000_0700, 32'h0, 32'h200C);
      flush_in = 1'b1;
      step();
      idle_inputs();
      check("fl_req", mem_req, 0);
      check("fl_valid", valid_out, 0);
      check("fl_stall", stall_out, 0);

      // Flush and new input during ACCESS are ignored
      issue(1'b1, 1'b0, 1'b1, 3'b010, 5'd6, 32'h0000_0800, 32'h0, 32'h2010);
      step();
      issue(1'b0, 1'b0, 1'b1, 3'b000, 5'd1, 32'h0000_9999, 32'h0, 32'h3000);
      flush_in = 1'b1;
      step();
      step();
      check("fa_req", mem_req, 1);
      check("fa_addr", mem_addr, 32'h800);
      idle_inputs();
      mem_ack   = 1'b1;
      mem_rdata = 32'h1357_9BDF;
      step();
      mem_ack = 1'b0;
      check("fa_valid", valid_out, 1);
      check("fa_rw", reg_write_out, 1);
      check("fa_alu", alu_result_out, 32'h800);
      check("fa_ldata", load_data_out, 32'h1357_9BDF);
      step();

      // Timeout: no ack for an LW
      issue(1'b1, 1'b0, 1'b1, 3'b010, 5'd8, 32'h0000_0500, 32'h0, 32'h2014);
      step();
      idle_inputs();
      n = 0;
      while (mem_req && n < 40) begin
         n++;
         step();
      end
      check("to_cycles", n, 16);
      check("to_valid", valid_out, 1);
      check("to_rw", reg_write_out, 0);
      check("to_terr", timeout_err, 1);
      step();
      issue(1'b0, 1'b0, 1'b1, 3'b000, 5'd2, 32'h0000_0011, 32'h0, 32'h2018);
      step();
      idle_inputs();
      check("to_sticky", timeout_err, 1);
      check("to_rt_rw", reg_write_out, 1);

      // Reset in the middle of ACCESS
      issue(1'b1, 1'b0, 1'b1, 3'b010, 5'd5, 32'h0000_0900, 32'h0, 32'h201C);
      step();
      idle_inputs();
      step();
      rst = 1'b1;
      #1;
      check("mr_req", mem_req, 0);
      check("mr_stall", stall_out, 0);
      check("mr_valid", valid_out, 0);
      check("mr_addr", mem_addr, 0);
      check("mr_mask", mem_mask, 0);
      check("mr_terr", timeout_err, 0);
      check("mr_instr", instruction_out, 0);
      #2;
      rst = 1'b0;
      step();
      issue(1'b1, 1'b0, 1'b1, 3'b010, 5'd10, 32'h0000_0200, 32'h0, 32'h2020);
      step();
      idle_inputs();
      check("lw_req", mem_req, 1);
      check("lw_mask", mem_mask, 4'b1111);
      step();
      mem_ack   = 1'b1;
      mem_rdata = 32'hCAFE_0042;
      step();
      mem_ack = 1'b0;
      check("lw_valid", valid_out, 1);
      check("lw_rw", reg_write_out, 1);
      check("lw_ldata", load_data_out, 32'hCAFE_0042);
      check("lw_rd", rd_addr_out, 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
